// File: rtl/player_sprite_gen_if.sv
// Raster, game-logic and sprite-address signals shared by the player sprite
// generator and whatever drives it (game logic plus the VGA raster counter).
interface player_sprite_gen_if;
  logic        frame_tick;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  PosX;
  logic [9:0]  PosY;
  logic        moving;
  logic        jump_req;
  logic        hit;
  logic        facing_left;
  logic [17:0] addr;
  logic        draw;
  logic [1:0]  anim_state;

  modport master (
    output frame_tick, DrawX, DrawY, PosX, PosY,
    output moving, jump_req, hit, facing_left,
    input  addr, draw, anim_state
  );

  modport slave (
    input  frame_tick, DrawX, DrawY, PosX, PosY,
    input  moving, jump_req, hit, facing_left,
    output addr, draw, anim_state
  );
endinterface

// File: rtl/player_sprite_gen.sv
// Per-player sprite address generator: latches position/facing once per frame,
// runs the idle/walk/jump/hit animation FSM and maps the raster pixel to a ROM address.
module player_sprite_gen #(
  parameter int          SPRITE_W    = 32,
  parameter int          SPRITE_H    = 32,
  parameter logic [17:0] BASE_ADDR   = 18'd4096,
  parameter int          SHEET_W     = 256,
  parameter int          ANIM_DIV    = 6,
  parameter int          JUMP_FRAMES = 40,
  parameter int          HIT_FRAMES  = 30
) (
  input  logic               clk,
  input  logic               Reset,
  player_sprite_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2,
    HIT  = 2'd3
  } state_t;

  localparam int DUR_MAX = (JUMP_FRAMES > HIT_FRAMES) ? JUMP_FRAMES : HIT_FRAMES;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);
  localparam int DIV_W   = $clog2(ANIM_DIV + 1);

  state_t             state;
  state_t             state_n;
  logic [9:0]         pos_x;
  logic [9:0]         pos_y;
  logic               face;
  logic [1:0]         walk_phase;
  logic [1:0]         walk_phase_n;
  logic [DIV_W-1:0]   div_cnt;
  logic [DIV_W-1:0]   div_cnt_n;
  logic [DUR_W-1:0]   dur_cnt;
  logic [DUR_W-1:0]   dur_cnt_n;

  // Everything except reset advances only on frame_tick, so a frame never tears.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state      <= IDLE;
      pos_x      <= '0;
      pos_y      <= '0;
      face       <= 1'b0;
      walk_phase <= '0;
      div_cnt    <= '0;
      dur_cnt    <= '0;
    end else if (bus.frame_tick) begin
      state      <= state_n;
      pos_x      <= bus.PosX;
      pos_y      <= bus.PosY;
      face       <= bus.facing_left;
      walk_phase <= walk_phase_n;
      div_cnt    <= div_cnt_n;
      dur_cnt    <= dur_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    walk_phase_n = walk_phase;
    div_cnt_n    = div_cnt;
    dur_cnt_n    = dur_cnt;

    // A hit overrides everything, but cannot restart a hit already in progress.
    if (bus.hit && (state != HIT)) begin
      state_n   = HIT;
      dur_cnt_n = DUR_W'(HIT_FRAMES - 1);
    end else begin
      case (state)
        HIT: begin
          if (dur_cnt == '0) state_n = IDLE;
          else               dur_cnt_n = dur_cnt - 1'b1;
        end
        JUMP: begin
          if (dur_cnt == '0) state_n = bus.moving ? WALK : IDLE;
          else               dur_cnt_n = dur_cnt - 1'b1;
        end
        IDLE, WALK: begin
          if (bus.jump_req) begin
            state_n   = JUMP;
            dur_cnt_n = DUR_W'(JUMP_FRAMES - 1);
          end else if (state == IDLE) begin
            if (bus.moving) begin
              state_n      = WALK;
              walk_phase_n = '0;
              div_cnt_n    = '0;
            end
          end else if (!bus.moving) begin
            state_n = IDLE;
          end else if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
            div_cnt_n    = '0;
            walk_phase_n = walk_phase + 2'd1;
          end else begin
            div_cnt_n = div_cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // Walk animation always restarts from its first frame after any other state.
    if (state_n != WALK) begin
      walk_phase_n = '0;
      div_cnt_n    = '0;
    end
    if ((state_n == IDLE) || (state_n == WALK)) begin
      dur_cnt_n = '0;
    end
  end

  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_x;
  logic        in_y;
  logic        in_box;
  logic [2:0]  frame_idx;
  logic [9:0]  col;
  logic [17:0] addr_calc;

  // Zero-extended 11-bit differences: bit 10 set means the pixel is left of / above the box,
  // which keeps wrapped negatives from aliasing into it.
  assign dx     = {1'b0, bus.DrawX} - {1'b0, pos_x};
  assign dy     = {1'b0, bus.DrawY} - {1'b0, pos_y};
  assign in_x   = ~dx[10] && (dx[9:0] < 10'(SPRITE_W));
  assign in_y   = ~dy[10] && (dy[9:0] < 10'(SPRITE_H));
  assign in_box = in_x && in_y;

  always_comb begin
    frame_idx = 3'd0;
    case (state)
      IDLE:    frame_idx = 3'd0;
      WALK:    frame_idx = 3'd1 + {1'b0, walk_phase};
      JUMP:    frame_idx = 3'd5;
      HIT:     frame_idx = 3'd6;
      default: frame_idx = 3'd0;
    endcase
  end

  assign col       = face ? (10'(SPRITE_W - 1) - dx[9:0]) : dx[9:0];
  assign addr_calc = BASE_ADDR
                   + 18'(dy[9:0]) * 18'(SHEET_W)
                   + 18'(frame_idx) * 18'(SPRITE_W)
                   + 18'(col);

  assign bus.draw       = in_box;
  assign bus.addr       = in_box ? addr_calc : BASE_ADDR;
  assign bus.anim_state = state;

endmodule
